// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Moore sequencer for a 32-bit accumulator-style datapath.
//               Each instruction runs a fetch phase (F0-F3), then one to five
//               execute steps (E1-E5) selected by the opcode in ir[31:27].
//               Memory steps are held for MEM_WAIT cycles by a down-counter.
//               Opcode 11011 parks the sequencer in HALT until clr.
//               Optional feature macro: MUL_DIV_EN (enables mul/div execute
//               sequences; without it those opcodes behave as nop).
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit #(
  parameter int MEM_WAIT = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con,
  output logic [4:0]  alu_control,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Pout,
  output logic        Cout,
  output logic        MDROut,
  output logic        HIout,
  output logic        LOout,
  output logic        ZHIout,
  output logic        ZLOout,
  output logic        IRen,
  output logic        MARen,
  output logic        MDRen,
  output logic        Yen,
  output logic        Zen,
  output logic        Pen,
  output logic        HIen,
  output logic        LOen,
  output logic        ConIn,
  output logic        Read,
  output logic        Write,
  output logic        run
);

  typedef enum logic [3:0] {
    S_F0   = 4'd0,
    S_F1   = 4'd1,
    S_F2   = 4'd2,
    S_F3   = 4'd3,
    S_E1   = 4'd4,
    S_E2   = 4'd5,
    S_E3   = 4'd6,
    S_E4   = 4'd7,
    S_E5   = 4'd8,
    S_HALT = 4'd9
  } state_t;

  // Counter value loaded on entry to a memory step; reaching zero ends it.
  localparam logic [3:0] WAIT_RELOAD = 4'(MEM_WAIT - 1);

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam logic [4:0] ALU_INC = 5'b11111;

`ifdef MUL_DIV_EN
  localparam logic MUL_DIV = 1'b1;
`else
  localparam logic MUL_DIV = 1'b0;
`endif

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] opcode;
  logic [2:0] last_step;
  logic [2:0] exec_idx;
  logic       is_rr, is_negnot, is_imm, is_addr, is_mul_div, mem_step;
  logic       unused_ir;

  assign opcode    = ir[31:27];
  // Register fields are consumed by the datapath's register encoder, not here.
  assign unused_ir = ^ir[26:0];

  assign is_rr      = (opcode >= 5'b00011) && (opcode <= 5'b01011);
  assign is_negnot  = (opcode == OP_NEG) || (opcode == OP_NOT);
  assign is_imm     = (opcode >= 5'b01100) && (opcode <= 5'b01110);
  assign is_addr    = (opcode == OP_LD) || (opcode == OP_ST) || (opcode == OP_LDI);
  assign is_mul_div = MUL_DIV && ((opcode == OP_MUL) || (opcode == OP_DIV));
  assign mem_step   = ((state_q == S_E4) && (opcode == OP_LD)) ||
                      ((state_q == S_E5) && (opcode == OP_ST));

  // Number of execute steps for the current opcode (0 = nop / unimplemented).
  always_comb begin
    last_step = 3'd0;
    if ((opcode == OP_LD) || (opcode == OP_ST)) begin
      last_step = 3'd5;
    end else if ((opcode == OP_BR) || is_mul_div) begin
      last_step = 3'd4;
    end else if (is_rr || is_negnot || is_imm || (opcode == OP_LDI)) begin
      last_step = 3'd3;
    end else if ((opcode == OP_JR) || (opcode == OP_MFHI) || (opcode == OP_MFLO)) begin
      last_step = 3'd1;
    end
  end

  // Position of the current state within the execute sequence.
  always_comb begin
    exec_idx = 3'd0;
    case (state_q)
      S_E1:    exec_idx = 3'd1;
      S_E2:    exec_idx = 3'd2;
      S_E3:    exec_idx = 3'd3;
      S_E4:    exec_idx = 3'd4;
      S_E5:    exec_idx = 3'd5;
      default: exec_idx = 3'd0;
    endcase
  end

  // Next-state and wait-counter logic; the counter reloads on every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = WAIT_RELOAD;
    case (state_q)
      S_F0: state_d = S_F1;
      S_F1: state_d = S_F2;
      S_F2: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = S_F3;
      end
      S_F3: begin
        if (opcode == OP_HALT)      state_d = S_HALT;
        else if (last_step == 3'd0) state_d = S_F0;
        else                        state_d = S_E1;
      end
      S_HALT: state_d = S_HALT;
      default: begin
        if (mem_step && (cnt_q != 4'd0)) cnt_d = cnt_q - 4'd1;
        else if (exec_idx >= last_step)  state_d = S_F0;
        else                             state_d = state_t'(state_q + 4'd1);
      end
    endcase
  end

  // State register with synchronous clear back to the start of fetch.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_F0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Control strobe decode; everything is forced low while clr is held.
  always_comb begin
    alu_control = 5'd0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    Pout = 1'b0; Cout = 1'b0; MDROut = 1'b0; HIout = 1'b0; LOout = 1'b0;
    ZHIout = 1'b0; ZLOout = 1'b0;
    IRen = 1'b0; MARen = 1'b0; MDRen = 1'b0; Yen = 1'b0; Zen = 1'b0; Pen = 1'b0;
    HIen = 1'b0; LOen = 1'b0; ConIn = 1'b0;
    Read = 1'b0; Write = 1'b0;
    run = 1'b0;
    if (!clr) begin
      run = (state_q != S_HALT);
      case (state_q)
        S_F0: begin Pout = 1'b1; MARen = 1'b1; Zen = 1'b1; alu_control = ALU_INC; end
        S_F1: begin ZLOout = 1'b1; Pen = 1'b1; end
        S_F2: begin Read = 1'b1; MDRen = 1'b1; end
        S_F3: begin MDROut = 1'b1; IRen = 1'b1; end
        S_E1: begin
          if (is_rr || is_negnot || is_imm) begin
            Grb = 1'b1; Rout = 1'b1; Yen = 1'b1;
          end else if (is_addr) begin
            Grb = 1'b1; Rout = 1'b1; BAout = 1'b1; Yen = 1'b1;
          end else if (opcode == OP_BR) begin
            Gra = 1'b1; Rout = 1'b1; ConIn = 1'b1;
          end else if (opcode == OP_JR) begin
            Gra = 1'b1; Rout = 1'b1; Pen = 1'b1;
          end else if (opcode == OP_MFHI) begin
            HIout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end else if (opcode == OP_MFLO) begin
            LOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end else if (is_mul_div) begin
            Gra = 1'b1; Rout = 1'b1; Yen = 1'b1;
          end
        end
        S_E2: begin
          if (is_rr) begin
            Grc = 1'b1; Rout = 1'b1; Zen = 1'b1; alu_control = opcode;
          end else if (is_negnot || is_mul_div) begin
            Grb = 1'b1; Rout = 1'b1; Zen = 1'b1; alu_control = opcode;
          end else if (is_imm) begin
            Cout = 1'b1; Zen = 1'b1; alu_control = opcode;
          end else if (is_addr) begin
            Cout = 1'b1; Zen = 1'b1; alu_control = OP_ADD;
          end else if (opcode == OP_BR) begin
            Pout = 1'b1; Yen = 1'b1;
          end
        end
        S_E3: begin
          if (is_rr || is_negnot || is_imm || (opcode == OP_LDI)) begin
            ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end else if ((opcode == OP_LD) || (opcode == OP_ST)) begin
            ZLOout = 1'b1; MARen = 1'b1;
          end else if (opcode == OP_BR) begin
            Cout = 1'b1; Zen = 1'b1; alu_control = OP_ADD;
          end else if (is_mul_div) begin
            ZLOout = 1'b1; LOen = 1'b1;
          end
        end
        S_E4: begin
          if (opcode == OP_LD) begin
            Read = 1'b1; MDRen = 1'b1;
          end else if (opcode == OP_ST) begin
            Gra = 1'b1; Rout = 1'b1; MDRen = 1'b1;
          end else if (opcode == OP_BR) begin
            ZLOout = 1'b1; Pen = con;
          end else if (is_mul_div) begin
            ZHIout = 1'b1; HIen = 1'b1;
          end
        end
        S_E5: begin
          if (opcode == OP_LD) begin
            MDROut = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end else if (opcode == OP_ST) begin
            Write = 1'b1;
          end
        end
        default: begin end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_control_unit
// Description : Scoreboard bench for control_unit. Two instances (MEM_WAIT=1
//               and MEM_WAIT=3) share ir/con; the idle one is held in clr.
//               Expected per-cycle strobe vectors are queued from an
//               instruction-level model and compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit;

  localparam logic [29:0] M_GRA    = 30'h1 << 0;
  localparam logic [29:0] M_GRB    = 30'h1 << 1;
  localparam logic [29:0] M_GRC    = 30'h1 << 2;
  localparam logic [29:0] M_RIN    = 30'h1 << 3;
  localparam logic [29:0] M_ROUT   = 30'h1 << 4;
  localparam logic [29:0] M_BAOUT  = 30'h1 << 5;
  localparam logic [29:0] M_POUT   = 30'h1 << 6;
  localparam logic [29:0] M_COUT   = 30'h1 << 7;
  localparam logic [29:0] M_MDROUT = 30'h1 << 8;
  localparam logic [29:0] M_HIOUT  = 30'h1 << 9;
  localparam logic [29:0] M_LOOUT  = 30'h1 << 10;
  localparam logic [29:0] M_ZHIOUT = 30'h1 << 11;
  localparam logic [29:0] M_ZLOOUT = 30'h1 << 12;
  localparam logic [29:0] M_IREN   = 30'h1 << 13;
  localparam logic [29:0] M_MAREN  = 30'h1 << 14;
  localparam logic [29:0] M_MDREN  = 30'h1 << 15;
  localparam logic [29:0] M_YEN    = 30'h1 << 16;
  localparam logic [29:0] M_ZEN    = 30'h1 << 17;
  localparam logic [29:0] M_PEN    = 30'h1 << 18;
  localparam logic [29:0] M_HIEN   = 30'h1 << 19;
  localparam logic [29:0] M_LOEN   = 30'h1 << 20;
  localparam logic [29:0] M_CONIN  = 30'h1 << 21;
  localparam logic [29:0] M_READ   = 30'h1 << 22;
  localparam logic [29:0] M_WRITE  = 30'h1 << 23;
  localparam logic [29:0] M_RUN    = 30'h1 << 24;

  localparam logic [31:0] IR_NOP  = 32'hD000_0000;
  localparam logic [31:0] IR_HALT = 32'hD800_0000;
  localparam logic [31:0] IR_ADD  = 32'h1891_8000;

  logic        clk = 1'b0;
  logic        clr_a, clr_b, con;
  logic [31:0] ir;
  wire  [29:0] obs_a, obs_b;

  int          checks = 0;
  int          errors = 0;
  logic [29:0] exp_q[$];

  always #5 clk = ~clk;

  control_unit #(.MEM_WAIT(1)) dut_a (
    .clk(clk), .clr(clr_a), .ir(ir), .con(con),
    .alu_control(obs_a[29:25]),
    .Gra(obs_a[0]), .Grb(obs_a[1]), .Grc(obs_a[2]), .Rin(obs_a[3]), .Rout(obs_a[4]),
    .BAout(obs_a[5]), .Pout(obs_a[6]), .Cout(obs_a[7]), .MDROut(obs_a[8]),
    .HIout(obs_a[9]), .LOout(obs_a[10]), .ZHIout(obs_a[11]), .ZLOout(obs_a[12]),
    .IRen(obs_a[13]), .MARen(obs_a[14]), .MDRen(obs_a[15]), .Yen(obs_a[16]),
    .Zen(obs_a[17]), .Pen(obs_a[18]), .HIen(obs_a[19]), .LOen(obs_a[20]),
    .ConIn(obs_a[21]), .Read(obs_a[22]), .Write(obs_a[23]), .run(obs_a[24])
  );

  control_unit #(.MEM_WAIT(3)) dut_b (
    .clk(clk), .clr(clr_b), .ir(ir), .con(con),
    .alu_control(obs_b[29:25]),
    .Gra(obs_b[0]), .Grb(obs_b[1]), .Grc(obs_b[2]), .Rin(obs_b[3]), .Rout(obs_b[4]),
    .BAout(obs_b[5]), .Pout(obs_b[6]), .Cout(obs_b[7]), .MDROut(obs_b[8]),
    .HIout(obs_b[9]), .LOout(obs_b[10]), .ZHIout(obs_b[11]), .ZLOout(obs_b[12]),
    .IRen(obs_b[13]), .MARen(obs_b[14]), .MDRen(obs_b[15]), .Yen(obs_b[16]),
    .Zen(obs_b[17]), .Pen(obs_b[18]), .HIen(obs_b[19]), .LOen(obs_b[20]),
    .ConIn(obs_b[21]), .Read(obs_b[22]), .Write(obs_b[23]), .run(obs_b[24])
  );

  function automatic logic [29:0] alu(input logic [4:0] op);
    return {op, 25'd0};
  endfunction

  // Model: fetch phase of any instruction.
  task automatic push_fetch(input int mw);
    exp_q.push_back(M_RUN | M_POUT | M_MAREN | M_ZEN | alu(5'b11111));
    exp_q.push_back(M_RUN | M_ZLOOUT | M_PEN);
    for (int i = 0; i < mw; i++) exp_q.push_back(M_RUN | M_READ | M_MDREN);
    exp_q.push_back(M_RUN | M_MDROUT | M_IREN);
  endtask

  // Model: execute steps by opcode class.
  task automatic push_exec(input logic [4:0] op, input logic c, input int mw);
    logic [29:0] r;
    r = M_RUN;
    if ((op >= 5'd3 && op <= 5'd11) || op == 5'd17 || op == 5'd18) begin
      exp_q.push_back(r | M_GRB | M_ROUT | M_YEN);
      exp_q.push_back(r | ((op == 5'd17 || op == 5'd18) ? M_GRB : M_GRC) | M_ROUT | M_ZEN | alu(op));
      exp_q.push_back(r | M_ZLOOUT | M_GRA | M_RIN);
    end else if (op >= 5'd12 && op <= 5'd14) begin
      exp_q.push_back(r | M_GRB | M_ROUT | M_YEN);
      exp_q.push_back(r | M_COUT | M_ZEN | alu(op));
      exp_q.push_back(r | M_ZLOOUT | M_GRA | M_RIN);
    end else if (op <= 5'd2) begin
      exp_q.push_back(r | M_GRB | M_ROUT | M_BAOUT | M_YEN);
      exp_q.push_back(r | M_COUT | M_ZEN | alu(5'd3));
      if (op == 5'd1) begin
        exp_q.push_back(r | M_ZLOOUT | M_GRA | M_RIN);
      end else begin
        exp_q.push_back(r | M_ZLOOUT | M_MAREN);
        if (op == 5'd0) begin
          for (int i = 0; i < mw; i++) exp_q.push_back(r | M_READ | M_MDREN);
          exp_q.push_back(r | M_MDROUT | M_GRA | M_RIN);
        end else begin
          exp_q.push_back(r | M_GRA | M_ROUT | M_MDREN);
          for (int i = 0; i < mw; i++) exp_q.push_back(r | M_WRITE);
        end
      end
    end else if (op == 5'd19) begin
      exp_q.push_back(r | M_GRA | M_ROUT | M_CONIN);
      exp_q.push_back(r | M_POUT | M_YEN);
      exp_q.push_back(r | M_COUT | M_ZEN | alu(5'd3));
      exp_q.push_back(r | M_ZLOOUT | (c ? M_PEN : 30'h0));
    end else if (op == 5'd20) begin
      exp_q.push_back(r | M_GRA | M_ROUT | M_PEN);
    end else if (op == 5'd24) begin
      exp_q.push_back(r | M_HIOUT | M_GRA | M_RIN);
    end else if (op == 5'd25) begin
      exp_q.push_back(r | M_LOOUT | M_GRA | M_RIN);
    end else if (op == 5'd15 || op == 5'd16) begin
`ifdef MUL_DIV_EN
      exp_q.push_back(r | M_GRA | M_ROUT | M_YEN);
      exp_q.push_back(r | M_GRB | M_ROUT | M_ZEN | alu(op));
      exp_q.push_back(r | M_ZLOOUT | M_LOEN);
      exp_q.push_back(r | M_ZHIOUT | M_HIEN);
`endif
    end
  endtask

  // Samples the selected instance mid-cycle, then advances to the next frame.
  task automatic next_cycle(input bit use_b, output logic [29:0] obs);
    @(negedge clk);
    obs = use_b ? obs_b : obs_a;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [29:0] obs, exp;
    clr_a = 1'b1; clr_b = 1'b1; ir = IR_NOP; con = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      next_cycle(1'b0, obs);
      checks++;
      if (obs !== 30'h0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %h want %h", i, obs, 30'h0);
      end
    end
    clr_a = 1'b0;
    push_fetch(1);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      next_cycle(1'b0, obs);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reset_release_fetch: got %h want %h", obs, exp);
      end
    end
  endtask

  task automatic test_alu_ops();
    logic [29:0] obs, exp;
    logic [4:0]  ops[14];
    int          len;
    ops = '{5'd3, 5'd4, 5'd11, 5'd17, 5'd18, 5'd12, 5'd14, 5'd1,
            5'd20, 5'd24, 5'd25, 5'd26, 5'd31, 5'd21};
    foreach (ops[k]) begin
      ir = (ops[k] == 5'd3) ? IR_ADD : {ops[k], 4'd1, 4'd2, 4'd3, 15'd0};
      push_fetch(1);
      push_exec(ops[k], 1'b0, 1);
      len = exp_q.size();
      if (ops[k] == 5'd3) begin
        checks++;
        if (len != 7) begin
          errors++;
          $display("FAIL add_length: got %0d want %0d", len, 7);
        end
      end
      while (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        next_cycle(1'b0, obs);
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL op_%b step %0d: got %h want %h", ops[k], len - exp_q.size() - 1, obs, exp);
        end
      end
    end
  endtask

  task automatic test_branch();
    logic [29:0] obs, exp;
    for (int c = 0; c < 2; c++) begin
      con = c[0];
      ir  = {5'd19, 4'd5, 23'd0};
      push_fetch(1);
      push_exec(5'd19, c[0], 1);
      while (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        next_cycle(1'b0, obs);
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL br_con%0d: got %h want %h", c, obs, exp);
        end
      end
    end
    con = 1'b0;
  endtask

  task automatic test_mul_div();
    logic [29:0] obs, exp;
    for (int k = 15; k <= 16; k++) begin
      ir = {5'(k), 4'd2, 4'd3, 19'd0};
      push_fetch(1);
      push_exec(5'(k), 1'b0, 1);
      // Ensure the next instruction starts with F0 straight after this one.
      exp_q.push_back(M_RUN | M_POUT | M_MAREN | M_ZEN | alu(5'b11111));
      while (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        next_cycle(1'b0, obs);
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL muldiv_%0d: got %h want %h", k, obs, exp);
        end
      end
      // Finish the nop fetch that began above so the next test starts at F0.
      ir = IR_NOP;
      exp_q.push_back(M_RUN | M_ZLOOUT | M_PEN);
      exp_q.push_back(M_RUN | M_READ | M_MDREN);
      exp_q.push_back(M_RUN | M_MDROUT | M_IREN);
      while (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        next_cycle(1'b0, obs);
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL muldiv_tail_%0d: got %h want %h", k, obs, exp);
        end
      end
    end
  endtask

  task automatic test_halt();
    logic [29:0] obs, exp;
    ir = IR_HALT;
    push_fetch(1);
    for (int i = 0; i < 100; i++) exp_q.push_back(30'h0);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      next_cycle(1'b0, obs);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL halt: got %h want %h", obs, exp);
      end
    end
    clr_a = 1'b1;
    exp_q.push_back(30'h0);
    exp = exp_q.pop_front();
    next_cycle(1'b0, obs);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL halt_clr: got %h want %h", obs, exp);
    end
    clr_a = 1'b0;
    ir = IR_NOP;
    push_fetch(1);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      next_cycle(1'b0, obs);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL halt_resume: got %h want %h", obs, exp);
      end
    end
  endtask

  task automatic test_mem_wait();
    logic [29:0] obs, exp;
    int          len;
    clr_a = 1'b1;
    clr_b = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ir = {(k == 0) ? 5'd0 : 5'd2, 4'd1, 4'd2, 19'h10};
      push_fetch(3);
      push_exec((k == 0) ? 5'd0 : 5'd2, 1'b0, 3);
      len = exp_q.size();
      if (k == 0) begin
        checks++;
        if (len != 13) begin
          errors++;
          $display("FAIL ld_length: got %0d want %0d", len, 13);
        end
      end
      while (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        next_cycle(1'b1, obs);
        checks++;
        if (obs !== exp || (obs[22] && obs[23])) begin
          errors++;
          $display("FAIL %s_mw3: got %h want %h", (k == 0) ? "ld" : "st", obs, exp);
        end
      end
    end
    // Clear in the middle of a memory wait, then check a full-length fetch wait.
    ir = {5'd0, 27'd0};
    exp_q.push_back(M_RUN | M_POUT | M_MAREN | M_ZEN | alu(5'b11111));
    exp_q.push_back(M_RUN | M_ZLOOUT | M_PEN);
    exp_q.push_back(M_RUN | M_READ | M_MDREN);
    exp_q.push_back(M_RUN | M_READ | M_MDREN);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      next_cycle(1'b1, obs);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL midwait_pre: got %h want %h", obs, exp);
      end
    end
    clr_b = 1'b1;
    next_cycle(1'b1, obs);
    checks++;
    if (obs !== 30'h0) begin
      errors++;
      $display("FAIL midwait_clr: got %h want %h", obs, 30'h0);
    end
    clr_b = 1'b0;
    ir = IR_NOP;
    push_fetch(3);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      next_cycle(1'b1, obs);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL midwait_refetch: got %h want %h", obs, exp);
      end
    end
    clr_b = 1'b1;
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_branch();
    test_mul_div();
    test_halt();
    test_mem_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
